// File: rtl/mem_resp_ctrl.sv
// mem_resp_ctrl: multi-cycle data-memory responder for the MEM stage.
// Accepts one load/store at a time, holds it for LATENCY busy cycles,
// then produces a single-cycle response. Byte lanes are big-endian.
module mem_resp_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Req_Valid,
  input  logic        Req_Write,
  input  logic [1:0]  Req_Size,
  input  logic        Req_Signed,
  input  logic [31:0] Req_Addr,
  input  logic [31:0] Req_WData,
  output logic        Req_Ready,
  output logic        Resp_Valid,
  output logic [31:0] Resp_RData,
  output logic        Resp_Err,
  output logic        Stall
);

  localparam int          ADDR_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RANGE_MASK = ~((32'(DEPTH_WORDS) << 2) - 32'd1);
  localparam logic [3:0]  CNT_LOAD   = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        cnt;

  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;

  logic [31:0]       mem [DEPTH_WORDS];

  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       cur_word;
  logic              misaligned;
  logic              out_of_range;
  logic              access_err;
  logic              finishing;
  logic              commit_store;
  logic [4:0]        lane_shift;
  logic [31:0]       lane_word;
  logic [31:0]       store_mask;
  logic [31:0]       store_data;
  logic [31:0]       merged_word;
  logic [31:0]       load_data;

  assign Req_Ready  = (state == IDLE);
  assign Resp_Valid = (state == RESP);
  assign Stall      = ((state == IDLE) && Req_Valid) || (state == BUSY);

  assign word_idx     = req_addr[ADDR_W+1:2];
  assign cur_word     = mem[word_idx];
  assign finishing    = (state == BUSY) && (cnt == 4'd0);
  assign commit_store = finishing && req_write && !access_err;

  // Classify the latched request: misaligned sub-word/word access or address beyond the array
  always_comb begin
    misaligned   = 1'b0;
    out_of_range = ((req_addr & RANGE_MASK) != 32'd0);
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      default: misaligned = (req_addr[1:0] != 2'b00);
    endcase
    access_err = misaligned || out_of_range;
  end

  // Big-endian lane steering: offset 0 lives in the top byte, so the shift shrinks as the offset grows
  always_comb begin
    lane_shift = 5'd0;
    store_mask = 32'hFFFF_FFFF;
    case (req_size)
      2'b00: begin
        lane_shift = {~req_addr[1:0], 3'b000};
        store_mask = 32'h0000_00FF << lane_shift;
      end
      2'b01: begin
        lane_shift = {~req_addr[1], 4'b0000};
        store_mask = 32'h0000_FFFF << lane_shift;
      end
      default: begin
        lane_shift = 5'd0;
        store_mask = 32'hFFFF_FFFF;
      end
    endcase
    store_data  = req_wdata << lane_shift;
    merged_word = (cur_word & ~store_mask) | (store_data & store_mask);
    lane_word   = cur_word >> lane_shift;
  end

  // Extend the selected lane to a full word for lb/lbu/lh/lhu/lw
  always_comb begin
    load_data = lane_word;
    case (req_size)
      2'b00:   load_data = {{24{req_signed & lane_word[7]}}, lane_word[7:0]};
      2'b01:   load_data = {{16{req_signed & lane_word[15]}}, lane_word[15:0]};
      default: load_data = lane_word;
    endcase
  end

  // Request FSM: latch on accept, count out the busy window, emit one response cycle
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_write  <= 1'b0;
      req_size   <= 2'b00;
      req_signed <= 1'b0;
      req_addr   <= 32'd0;
      req_wdata  <= 32'd0;
      Resp_RData <= 32'd0;
      Resp_Err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Req_Valid) begin
            req_write  <= Req_Write;
            req_size   <= Req_Size;
            req_signed <= Req_Signed;
            req_addr   <= Req_Addr;
            req_wdata  <= Req_WData;
            cnt        <= CNT_LOAD;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state      <= RESP;
            Resp_Err   <= access_err;
            Resp_RData <= (access_err || req_write) ? 32'd0 : load_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state      <= IDLE;
          Resp_RData <= 32'd0;
          Resp_Err   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Data array has no reset; a store lands only on the BUSY->RESP edge of an error-free request
  always_ff @(posedge CLK) begin
    if (commit_store) begin
      mem[word_idx] <= merged_word;
    end
  end

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// tb_mem_resp_ctrl: directed bench for mem_resp_ctrl with a byte-addressed
// reference memory and a per-cycle output comparator.
module tb_mem_resp_ctrl;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int BW    = $clog2(DEPTH * 4);

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        Req_Valid = 1'b0;
  logic        Req_Write = 1'b0;
  logic [1:0]  Req_Size = 2'b00;
  logic        Req_Signed = 1'b0;
  logic [31:0] Req_Addr = 32'd0;
  logic [31:0] Req_WData = 32'd0;
  logic        Req_Ready;
  logic        Resp_Valid;
  logic [31:0] Resp_RData;
  logic        Resp_Err;
  logic        Stall;

  int n_checks = 0;
  int n_pass   = 0;

  mem_resp_ctrl #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .Req_Valid (Req_Valid),
    .Req_Write (Req_Write),
    .Req_Size  (Req_Size),
    .Req_Signed(Req_Signed),
    .Req_Addr  (Req_Addr),
    .Req_WData (Req_WData),
    .Req_Ready (Req_Ready),
    .Resp_Valid(Resp_Valid),
    .Resp_RData(Resp_RData),
    .Resp_Err  (Resp_Err),
    .Stall     (Stall)
  );

  always #5 CLK = ~CLK;

  // Reference model: byte-addressed memory plus the cycle number a request was accepted on
  logic [7:0]  mmem [DEPTH*4];
  int          m_cyc = 0;
  int          m_acc = 0;
  bit          m_active = 1'b0;
  bit          m_was_idle;
  int          m_prev;
  logic        m_write;
  logic [1:0]  m_size;
  logic        m_signed;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] exp_rdata = 32'd0;
  logic        exp_err = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic modelRespond();
    logic [BW-1:0] bi;
    logic          bad;
    int            val;
    bi  = m_addr[BW-1:0];
    bad = (m_size == 2'b01 && m_addr[0]) ||
          (m_size >= 2'b10 && m_addr[1:0] != 2'b00) ||
          (m_addr >= 32'(DEPTH * 4));
    if (bad) begin
      exp_err   = 1'b1;
      exp_rdata = 32'd0;
    end else if (m_write) begin
      exp_err   = 1'b0;
      exp_rdata = 32'd0;
      case (m_size)
        2'b00: mmem[bi] = m_wdata[7:0];
        2'b01: begin
          mmem[bi]          = m_wdata[15:8];
          mmem[bi + BW'(1)] = m_wdata[7:0];
        end
        default: begin
          mmem[bi]          = m_wdata[31:24];
          mmem[bi + BW'(1)] = m_wdata[23:16];
          mmem[bi + BW'(2)] = m_wdata[15:8];
          mmem[bi + BW'(3)] = m_wdata[7:0];
        end
      endcase
    end else begin
      exp_err = 1'b0;
      case (m_size)
        2'b00: begin
          val = int'(mmem[bi]);
          if (m_signed && val >= 128) val = val - 256;
          exp_rdata = 32'(val);
        end
        2'b01: begin
          val = int'(mmem[bi]) * 256 + int'(mmem[bi + BW'(1)]);
          if (m_signed && val >= 32768) val = val - 65536;
          exp_rdata = 32'(val);
        end
        default: exp_rdata = {mmem[bi], mmem[bi + BW'(1)], mmem[bi + BW'(2)], mmem[bi + BW'(3)]};
      endcase
    end
  endtask

  // Model advance: response is due LAT cycles after acceptance and lasts one cycle
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_active = 1'b0;
      m_cyc    = 0;
    end else begin
      m_prev     = m_cyc;
      m_cyc      = m_cyc + 1;
      m_was_idle = !m_active;
      if (m_active && m_prev == m_acc + LAT - 1) modelRespond();
      if (m_active && m_prev == m_acc + LAT) m_active = 1'b0;
      if (m_was_idle && Req_Valid) begin
        m_active = 1'b1;
        m_acc    = m_cyc;
        m_write  = Req_Write;
        m_size   = Req_Size;
        m_signed = Req_Signed;
        m_addr   = Req_Addr;
        m_wdata  = Req_WData;
      end
    end
  end

  // Per-cycle comparison of handshake/stall outputs, and of response data when a response is due
  logic e_busy;
  logic e_resp;
  always @(negedge CLK) begin
    e_resp = m_active && (m_cyc == m_acc + LAT);
    e_busy = m_active && (m_cyc < m_acc + LAT);
    checkOutput("cyc_ready", 32'(Req_Ready), 32'(!m_active));
    checkOutput("cyc_valid", 32'(Resp_Valid), 32'(e_resp));
    checkOutput("cyc_stall", 32'(Stall), 32'(e_busy || (!m_active && Req_Valid)));
    if (e_resp) begin
      checkOutput("cyc_rdata", Resp_RData, exp_rdata);
      checkOutput("cyc_err", 32'(Resp_Err), 32'(exp_err));
    end
  end

  // Present one request in an idle cycle, scramble inputs while busy, wait (bounded) for the response
  task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic sg,
                               input logic [31:0] addr, input logic [31:0] wd,
                               output logic [31:0] rd, output logic er,
                               output int lat, output int stalls);
    rd     = 32'hxxxx_xxxx;
    er     = 1'bx;
    lat    = -1;
    stalls = 0;
    @(posedge CLK);
    #1;
    Req_Valid  = 1'b1;
    Req_Write  = w;
    Req_Size   = sz;
    Req_Signed = sg;
    Req_Addr   = addr;
    Req_WData  = wd;
    @(negedge CLK);
    if (Stall) stalls++;
    @(posedge CLK);
    #1;
    Req_Valid  = 1'b0;
    Req_Write  = 1'b1;
    Req_Size   = 2'b10;
    Req_Signed = 1'b1;
    Req_Addr   = 32'd0;
    Req_WData  = 32'h0BAD_0BAD;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (Stall) stalls++;
      if (Resp_Valid) begin
        rd  = Resp_RData;
        er  = Resp_Err;
        lat = k;
        break;
      end
    end
    if (lat < 0) checkOutput("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic doAccess(input string name, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          stalls;
    applyStimulus(w, sz, sg, addr, wd, rd, er, lat, stalls);
    checkOutput({name, "_rdata"}, rd, exp_rd);
    checkOutput({name, "_err"}, 32'(er), 32'(exp_er));
    checkOutput({name, "_latency"}, 32'(lat), 32'(LAT + 1));
    checkOutput({name, "_stalls"}, 32'(stalls), 32'(LAT + 1));
  endtask

  int resp_count;
  int first_resp;
  int last_resp;
  int min_gap;

  initial begin
    #1;
    $display("[TB] reset state");
    checkOutput("rst_ready", 32'(Req_Ready), 32'd1);
    checkOutput("rst_valid", 32'(Resp_Valid), 32'd0);
    checkOutput("rst_rdata", Resp_RData, 32'd0);
    checkOutput("rst_err", 32'(Resp_Err), 32'd0);
    checkOutput("rst_stall_lo", 32'(Stall), 32'd0);
    Req_Valid = 1'b1;
    #1;
    checkOutput("rst_stall_hi", 32'(Stall), 32'd1);
    Req_Valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #2 RESET = 1'b0;

    $display("[TB] word, byte and half accesses");
    doAccess("sw_0x10",   1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, 32'h0000_0000, 1'b0);
    doAccess("lw_0x10",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h1234_5678, 1'b0);
    doAccess("lb_0x10",   1'b0, 2'b00, 1'b1, 32'h10, 32'h0,         32'h0000_0012, 1'b0);
    doAccess("sb_0x13",   1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00F0, 32'h0000_0000, 1'b0);
    doAccess("lb_0x13",   1'b0, 2'b00, 1'b1, 32'h13, 32'h0,         32'hFFFF_FFF0, 1'b0);
    doAccess("lbu_0x13",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0,         32'h0000_00F0, 1'b0);
    doAccess("lw2_0x10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h1234_56F0, 1'b0);
    doAccess("lh_0x12",   1'b0, 2'b01, 1'b1, 32'h12, 32'h0,         32'h0000_56F0, 1'b0);
    doAccess("sh_0x10",   1'b1, 2'b01, 1'b0, 32'h10, 32'h0000_8001, 32'h0000_0000, 1'b0);
    doAccess("lh_0x10",   1'b0, 2'b01, 1'b1, 32'h10, 32'h0,         32'hFFFF_8001, 1'b0);
    doAccess("lw3_0x10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h8001_56F0, 1'b0);

    $display("[TB] error accesses");
    doAccess("sw_0x00",   1'b1, 2'b10, 1'b0, 32'h00, 32'hA5A5_5A5A, 32'h0000_0000, 1'b0);
    doAccess("lw_0x00",   1'b0, 2'b10, 1'b0, 32'h00, 32'h0,         32'hA5A5_5A5A, 1'b0);
    doAccess("lw_0x11",   1'b0, 2'b10, 1'b0, 32'h11, 32'h0,         32'h0000_0000, 1'b1);
    doAccess("lh_0x11",   1'b0, 2'b01, 1'b1, 32'h11, 32'h0,         32'h0000_0000, 1'b1);
    doAccess("sw_0x400",  1'b1, 2'b10, 1'b0, 32'h400, 32'h1111_1111, 32'h0000_0000, 1'b1);
    doAccess("lb_0x800",  1'b0, 2'b00, 1'b1, 32'h800, 32'h0,        32'h0000_0000, 1'b1);
    doAccess("lw2_0x00",  1'b0, 2'b10, 1'b0, 32'h00, 32'h0,         32'hA5A5_5A5A, 1'b0);
    doAccess("lw4_0x10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h8001_56F0, 1'b0);
    doAccess("lw_sz3",    1'b0, 2'b11, 1'b0, 32'h00, 32'h0,         32'hA5A5_5A5A, 1'b0);

    $display("[TB] reset during a pending store");
    doAccess("sw_0x20",   1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D, 32'h0000_0000, 1'b0);
    @(posedge CLK);
    #1;
    Req_Valid = 1'b1;
    Req_Write = 1'b1;
    Req_Size  = 2'b10;
    Req_Addr  = 32'h20;
    Req_WData = 32'hDEAD_BEEF;
    @(posedge CLK);
    #1;
    Req_Valid = 1'b0;
    #2 RESET = 1'b1;
    #1;
    checkOutput("mid_rst_ready", 32'(Req_Ready), 32'd1);
    checkOutput("mid_rst_valid", 32'(Resp_Valid), 32'd0);
    checkOutput("mid_rst_rdata", Resp_RData, 32'd0);
    checkOutput("mid_rst_err", 32'(Resp_Err), 32'd0);
    checkOutput("mid_rst_stall", 32'(Stall), 32'd0);
    @(negedge CLK);
    #2 RESET = 1'b0;
    doAccess("lw_0x20",   1'b0, 2'b10, 1'b0, 32'h20, 32'h0,         32'hCAFE_F00D, 1'b0);

    $display("[TB] back-to-back requests with Req_Valid held high");
    resp_count = 0;
    first_resp = -1;
    last_resp  = -1;
    min_gap    = 1000;
    @(posedge CLK);
    for (int i = 0; i < 12; i++) begin
      #1;
      Req_Valid  = 1'b1;
      Req_Write  = 1'b0;
      case (i % 3)
        0:       begin Req_Size = 2'b10; Req_Signed = 1'b0; Req_Addr = 32'h10; end
        1:       begin Req_Size = 2'b00; Req_Signed = 1'b0; Req_Addr = 32'h11; end
        default: begin Req_Size = 2'b01; Req_Signed = 1'b1; Req_Addr = 32'h12; end
      endcase
      @(negedge CLK);
      if (Resp_Valid) begin
        resp_count++;
        if (first_resp < 0) first_resp = i;
        if (last_resp >= 0 && (i - last_resp) < min_gap) min_gap = i - last_resp;
        last_resp = i;
      end
      @(posedge CLK);
    end
    #1;
    Req_Valid = 1'b0;
    checkOutput("b2b_count", 32'(resp_count), 32'd3);
    checkOutput("b2b_first", 32'(first_resp), 32'(LAT + 1));
    checkOutput("b2b_gap", 32'(min_gap), 32'(LAT + 2));
    repeat (3) @(posedge CLK);
    @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
